// File: rtl/bus_source_mux.sv
// Transmit end of the shared 8-bit bus: drives busfin/busin from A, B, ALU or
// a small input FIFO, with req/ack toward the control unit.
module bus_source_mux #(
    parameter int IN_DEPTH = 4,
    parameter int WAIT_MAX = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [2:0] sel,
    input  logic [7:0] src_a,
    input  logic [7:0] src_b,
    input  logic [7:0] src_alu,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] busfin,
    output logic       busin,
    output logic       ack,
    output logic       busy,
    output logic       err
);

    localparam int AW = $clog2(IN_DEPTH);
    localparam logic [AW:0] FULL_CNT = IN_DEPTH[AW:0];
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [7:0]    mem_q [IN_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic [0:0] state_q, state_d;
    logic [7:0] wcnt_q, wcnt_d;

    logic [7:0] busfin_q, busfin_d;
    logic       busin_q, busin_d;
    logic       ack_q, ack_d;
    logic       err_q, err_d;

    logic       full, empty, push, pop;
    logic [7:0] head;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        pop      = 1'b0;
        busfin_d = 8'h00;
        busin_d  = 1'b0;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    unique case (sel)
                        3'h1: begin
                            busfin_d = src_a;
                            busin_d  = 1'b1;
                            ack_d    = 1'b1;
                        end
                        3'h2: begin
                            busfin_d = src_b;
                            busin_d  = 1'b1;
                            ack_d    = 1'b1;
                        end
                        3'h3: begin
                            busfin_d = src_alu;
                            busin_d  = 1'b1;
                            ack_d    = 1'b1;
                        end
                        3'h4: begin
                            if (!empty) begin
                                pop      = 1'b1;
                                busfin_d = head;
                                busin_d  = 1'b1;
                                ack_d    = 1'b1;
                            end else begin
                                state_d = S_WAIT;
                                wcnt_d  = 8'd0;
                            end
                        end
                        default: begin
                            ack_d = 1'b1;
                            err_d = 1'b1;
                        end
                    endcase
                end
            end
            S_WAIT: begin
                // A word arriving on the last wait cycle still wins over the timeout.
                if (!empty) begin
                    pop      = 1'b1;
                    busfin_d = head;
                    busin_d  = 1'b1;
                    ack_d    = 1'b1;
                    state_d  = S_IDLE;
                end else if (wcnt_q == WAIT_LAST) begin
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                    wcnt_d  = 8'd0;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            wcnt_q   <= 8'd0;
            busfin_q <= 8'h00;
            busin_q  <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            busfin_q <= busfin_d;
            busin_q  <= busin_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign busfin = busfin_q;
    assign busin  = busin_q;
    assign ack    = ack_q;
    assign err    = err_q;
    assign busy   = (state_q == S_WAIT);

endmodule

// File: tb/tb_bus_source_mux.sv
// Bench for bus_source_mux: directed scenarios then random traffic,
// checked against a queue-based transfer model.
module tb_bus_source_mux;

    localparam int DEPTH = 4;
    localparam int WMAX  = 8;

    logic       clk = 1'b0;
    logic       rst, req, in_valid;
    logic [2:0] sel;
    logic [7:0] src_a, src_b, src_alu, in_data;
    logic       in_ready, busin, ack, busy, err;
    logic [7:0] busfin;

    int total = 0;
    int bad   = 0;

    logic [7:0] mq[$];
    bit         waiting = 0;
    int         waited  = 0;

    always #5 clk = ~clk;

    bus_source_mux #(.IN_DEPTH(DEPTH), .WAIT_MAX(WMAX)) dut (
        .clk(clk), .rst(rst), .req(req), .sel(sel),
        .src_a(src_a), .src_b(src_b), .src_alu(src_alu),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .busfin(busfin), .busin(busin), .ack(ack), .busy(busy), .err(err)
    );

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(bit r, bit q, logic [2:0] s, bit v, logic [7:0] d);
        rst      = r;
        req      = q;
        sel      = s;
        in_valid = v;
        in_data  = d;
    endtask

    // One clock: predict, advance, compare.
    task automatic tick();
        bit         rdy;
        int         avail;
        logic [7:0] e_fin;
        bit         e_in, e_ack, e_err;
        #1;
        rdy = (mq.size() < DEPTH) && !rst;
        chk("in_ready", {7'b0, in_ready}, {7'b0, rdy});
        e_fin = 8'h00;
        e_in  = 0;
        e_ack = 0;
        e_err = 0;
        if (rst) begin
            mq.delete();
            waiting = 0;
            waited  = 0;
        end else begin
            avail = mq.size();
            if (waiting) begin
                if (avail > 0) begin
                    e_fin   = mq.pop_front();
                    e_in    = 1;
                    e_ack   = 1;
                    waiting = 0;
                end else begin
                    waited++;
                    if (waited == WMAX) begin
                        e_ack   = 1;
                        e_err   = 1;
                        waiting = 0;
                    end
                end
            end else if (req) begin
                case (sel)
                    3'd1: begin e_fin = src_a;   e_in = 1; e_ack = 1; end
                    3'd2: begin e_fin = src_b;   e_in = 1; e_ack = 1; end
                    3'd3: begin e_fin = src_alu; e_in = 1; e_ack = 1; end
                    3'd4: begin
                        if (avail > 0) begin
                            e_fin = mq.pop_front();
                            e_in  = 1;
                            e_ack = 1;
                        end else begin
                            waiting = 1;
                            waited  = 0;
                        end
                    end
                    default: begin e_ack = 1; e_err = 1; end
                endcase
            end
            if (in_valid && rdy) mq.push_back(in_data);
        end
        @(posedge clk);
        #1;
        chk("busfin", busfin, e_fin);
        chk("busin", {7'b0, busin}, {7'b0, e_in});
        chk("ack", {7'b0, ack}, {7'b0, e_ack});
        chk("err", {7'b0, err}, {7'b0, e_err});
        chk("busy", {7'b0, busy}, {7'b0, waiting});
    endtask

    initial begin
        src_a   = 8'h00;
        src_b   = 8'h00;
        src_alu = 8'h00;
        drive(1, 0, 3'd0, 0, 8'h00);
        tick();
        tick();

        // single register A transfer
        src_a = 8'h5A;
        drive(0, 1, 3'h1, 0, 8'h00);
        tick();
        drive(0, 0, 3'h0, 0, 8'h00);
        tick();

        // back-to-back A, B, ALU
        src_a   = 8'h11;
        src_b   = 8'h22;
        src_alu = 8'h33;
        drive(0, 1, 3'h1, 0, 8'h00); tick();
        drive(0, 1, 3'h2, 0, 8'h00); tick();
        drive(0, 1, 3'h3, 0, 8'h00); tick();
        drive(0, 0, 3'h0, 0, 8'h00); tick();

        // fill FIFO, overfill attempt, then drain
        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, 3'h0, 1, 8'hA0 + 8'(i));
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 3'h4, 0, 8'h00);
            tick();
        end
        drive(0, 0, 3'h0, 0, 8'h00); tick();

        // wait for input, word arrives later
        drive(0, 1, 3'h4, 0, 8'h00); tick();
        drive(0, 0, 3'h0, 0, 8'h00);
        for (int i = 0; i < 4; i++) tick();
        drive(0, 0, 3'h0, 1, 8'hC3); tick();
        drive(0, 0, 3'h0, 0, 8'h00);
        for (int i = 0; i < 3; i++) tick();

        // timeout, then normal service
        drive(0, 1, 3'h4, 0, 8'h00); tick();
        drive(0, 0, 3'h0, 0, 8'h00);
        for (int i = 0; i < WMAX + 2; i++) tick();
        src_b = 8'h6B;
        drive(0, 1, 3'h2, 0, 8'h00); tick();

        // invalid select
        drive(0, 1, 3'h7, 0, 8'h00); tick();
        drive(0, 1, 3'h0, 0, 8'h00); tick();

        // reset while waiting
        drive(0, 1, 3'h4, 0, 8'h00); tick();
        drive(0, 0, 3'h0, 0, 8'h00); tick(); tick();
        drive(1, 0, 3'h0, 1, 8'hEE); tick();
        drive(0, 0, 3'h0, 0, 8'h00); tick(); tick();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            src_a   = 8'($urandom);
            src_b   = 8'($urandom);
            src_alu = 8'($urandom);
            drive(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 1) == 1),
                  3'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) == 0),
                  8'($urandom));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
